// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, instr} FIFO between fetch and decode with single-cycle flush
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [XLEN-1:0]          push_instr,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [XLEN-1:0]          pop_pc,
    output logic [XLEN-1:0]          pop_pcplus4,
    output logic [XLEN-1:0]          pop_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AFULL_LVL);
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push_fire, pop_fire;
    assign push_ready = count_q != FULL_C;
    assign pop_valid = count_q != '0;
    assign almost_full = count_q >= AF_C;
    assign count = count_q;
    assign push_fire = push_valid && push_ready;
    assign pop_fire = pop_valid && pop_ready;
    assign pop_pc = pc_q[rd_ptr_q];
    assign pop_pcplus4 = pop_pc + XLEN'(4);
    assign pop_instr = pop_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
    always_comb begin
        pc_d = pc_q;
        instr_d = instr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d = count_q;
        if (rst) begin
            pc_d = '{default: '0};
            instr_d = '{default: '0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d = '0;
        end else if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d = '0;
        end else begin
            if (push_fire) begin
                pc_d[wr_ptr_q] = push_pc;
                instr_d[wr_ptr_q] = push_instr;
            end
            wr_ptr_d = push_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_d = count_q + CW'(push_fire) - CW'(pop_fire);
        end
    end
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        instr_q <= instr_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q <= count_d;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= FULL_C);
            assert (count_q[AW-1:0] == AW'(wr_ptr_q - rd_ptr_q));
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue checked by a pop monitor
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic push_valid = 1'b0;
    logic push_ready;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic pop_valid;
    logic pop_ready = 1'b0;
    logic [31:0] pop_pc, pop_pcplus4, pop_instr;
    logic [2:0] count;
    logic almost_full;
    int checks = 0;
    int failures = 0;
    int mcount = 0;
    logic last_acc;
    logic [63:0] exp_q [$];

    fetch_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_instr(push_instr),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc(pop_pc), .pop_pcplus4(pop_pcplus4), .pop_instr(pop_instr),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h00100093 ^ (pc << 12);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs and advance the reference model for the coming edge.
    task automatic drive(input logic pv, input logic [31:0] pc, input logic pr, input logic fl, input logic r);
        logic acc_pop;
        push_valid = pv;
        push_pc = pc;
        push_instr = instr_of(pc);
        pop_ready = pr;
        flush = fl;
        rst = r;
        last_acc = pv && (mcount < 4);
        acc_pop = pr && (mcount > 0);
        if (r || fl) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (last_acc) exp_q.push_back({pc, instr_of(pc)});
            mcount = mcount + int'(last_acc) - int'(acc_pop);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && pop_valid && pop_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", pop_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_pc", pop_pc, e[63:32]);
                check("pop_pcplus4", pop_pcplus4, e[63:32] + 32'd4);
                check("pop_instr", pop_instr, e[31:0]);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_pop_valid"}, 32'(pop_valid), 32'd0);
        check({tag, "_push_ready"}, 32'(push_ready), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        check({tag, "_pop_instr"}, pop_instr, 32'h00000013);
        check({tag, "_pop_pc"}, pop_pc, 32'h0);
        check({tag, "_pop_pcplus4"}, pop_pcplus4, 32'h4);
    endtask

    initial begin
        logic [31:0] npc;
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 0, 0);
        check_reset_state("reset");
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 0, 0, 0);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 3));
            check("fill_push_ready", 32'(push_ready), 32'(i + 1 < 4));
        end
        drive(1, 32'h10, 0, 0, 0);
        tick();
        check("full_reject_count", 32'(count), 32'd4);
        npc = 32'h10;
        for (int i = 0; i < 10; i++) begin
            drive(1, npc, 1, 0, 0);
            tick();
            if (last_acc) npc = npc + 32'd4;
        end
        check("stream_count", 32'(count), 32'd3);
        drive(1, 32'h40, 0, 1, 0);
        tick();
        check("flush_count", 32'(count), 32'd0);
        check("flush_pop_valid", 32'(pop_valid), 32'd0);
        check("flush_pop_instr", pop_instr, 32'h00000013);
        drive(1, 32'h80, 0, 0, 0);
        check("latency_before", 32'(pop_valid), 32'd0);
        tick();
        check("latency_after", 32'(pop_valid), 32'd1);
        check("latency_pc", pop_pc, 32'h80);
        drive(1, 32'h84, 1, 0, 0);
        tick();
        check("pushpop1_count", 32'(count), 32'd1);
        check("pushpop1_pc", pop_pc, 32'h84);
        drive(0, 0, 1, 0, 0);
        tick();
        check("drain_count", 32'(count), 32'd0);
        drive(1, 32'hFFFFFFFC, 0, 0, 0);
        tick();
        check("wrap_pcplus4", pop_pcplus4, 32'h0);
        drive(0, 0, 1, 0, 0);
        tick();
        check("wrap_drain_count", 32'(count), 32'd0);
        drive(1, 32'h100, 0, 0, 0);
        tick();
        drive(1, 32'h104, 0, 0, 0);
        tick();
        check("pre_rst_count", 32'(count), 32'd2);
        drive(1, 32'h108, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        check_reset_state("mid_rst");
        drive(1, 32'h200, 0, 0, 0);
        tick();
        check("resume_count", 32'(count), 32'd1);
        check("resume_pc", pop_pc, 32'h200);
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        check("end_count", 32'(count), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
